// File: rtl/riscv_dtcm.sv
// rtl/riscv_dtcm.sv - tightly-coupled data memory responding on the core dmem interface
// Optional LR/SC reservation enabled by RV12_DTCM_LOCK_EN.

package riscv_dtcm_pkg;
    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011
    } biu_size_t;
endpackage

module riscv_dtcm
    import riscv_dtcm_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    parameter int              WAIT_STATES = 0
) (
    input  logic            rst_ni,
    input  logic            clk_i,
    input  logic            dmem_req_i,
    input  logic            dmem_lock_i,
    input  logic [XLEN-1:0] dmem_adr_i,
    input  biu_size_t       dmem_size_i,
    input  logic            dmem_we_i,
    input  logic [XLEN-1:0] dmem_d_i,
    output logic [XLEN-1:0] dmem_q_o,
    output logic            dmem_ack_o,
    output logic            dmem_misaligned_o,
    output logic            dmem_page_fault_o,
    output logic            dmem_err_o
);

    localparam int              NB        = XLEN / 8;
    localparam int              LSB       = $clog2(NB);
    localparam int              IDXW      = $clog2(DEPTH);
    localparam logic [XLEN-1:0] WIN_BYTES = XLEN'(DEPTH * NB);
    localparam logic [3:0]      WS        = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] adr_q, d_q, q_q, q_d;
    biu_size_t       size_q;
    logic            we_q, lock_q;
    logic            ack_q, mis_q, mis_d, err_q, err_d;
    logic [XLEN-1:0] mem [DEPTH];

    logic [XLEN-1:0] cur_adr, cur_d, offset;
    biu_size_t       cur_size;
    logic            cur_we, cur_lock;
    logic [NB-1:0]   be;
    logic [IDXW-1:0] idx;
    logic [LSB-1:0]  lane;
    logic            acc_err, acc_mis, acc_ok, commit, sc_fail, wr_en;

    // In IDLE the live request is classified so a zero-wait access commits on the sampling edge.
    always_comb begin
        cur_adr  = (state_q == S_IDLE) ? dmem_adr_i  : adr_q;
        cur_d    = (state_q == S_IDLE) ? dmem_d_i    : d_q;
        cur_size = (state_q == S_IDLE) ? dmem_size_i : size_q;
        cur_we   = (state_q == S_IDLE) ? dmem_we_i   : we_q;
        cur_lock = (state_q == S_IDLE) ? dmem_lock_i : lock_q;
        offset   = cur_adr - BASE_ADDR;
        idx      = offset[LSB +: IDXW];
        lane     = cur_adr[LSB-1:0];
        acc_err  = (offset >= WIN_BYTES);
        acc_mis  = 1'b0;
        be       = '0;
        case (cur_size)
            BYTE:  be = NB'(1) << lane;
            HWORD: begin be = NB'(3) << lane;  acc_mis = cur_adr[0];      end
            WORD:  begin be = NB'(15) << lane; acc_mis = |cur_adr[1:0];   end
            DWORD: begin
                be      = '1;
                acc_mis = |cur_adr[2:0];
                if (XLEN == 32) acc_err = 1'b1;
            end
            default: acc_err = 1'b1;
        endcase
        acc_mis = acc_mis & ~acc_err;
        acc_ok  = ~acc_err & ~acc_mis;
    end

`ifdef RV12_DTCM_LOCK_EN
    logic            resv_vld_q;
    logic [IDXW-1:0] resv_idx_q;

    assign sc_fail = cur_we & cur_lock & ~(resv_vld_q & (resv_idx_q == idx));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resv_vld_q <= 1'b0;
            resv_idx_q <= '0;
        end else if (commit && acc_ok) begin
            if (!cur_we && cur_lock) begin
                resv_vld_q <= 1'b1;
                resv_idx_q <= idx;
            end else if (cur_we && (cur_lock || resv_idx_q == idx)) begin
                resv_vld_q <= 1'b0;
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = cur_lock;
    assign sc_fail     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (dmem_req_i) begin
                    if (!acc_ok || WS == 4'd0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase

        commit = (state_d == S_RESP) && (state_q != S_RESP);
        // Gating on rst_ni keeps a request held through reset from writing the array.
        wr_en  = commit & acc_ok & cur_we & ~sc_fail & rst_ni;
        q_d    = '0;
        mis_d  = 1'b0;
        err_d  = 1'b0;
        if (commit) begin
            mis_d = acc_mis;
            err_d = acc_err;
            if (acc_ok) q_d = cur_we ? XLEN'(sc_fail) : mem[idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            d_q     <= '0;
            size_q  <= BYTE;
            we_q    <= 1'b0;
            lock_q  <= 1'b0;
            ack_q   <= 1'b0;
            q_q     <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && dmem_req_i) begin
                adr_q  <= dmem_adr_i;
                d_q    <= dmem_d_i;
                size_q <= dmem_size_i;
                we_q   <= dmem_we_i;
                lock_q <= dmem_lock_i;
            end
            ack_q <= commit;
            q_q   <= q_d;
            mis_q <= mis_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[idx][b*8 +: 8] <= cur_d[b*8 +: 8];
            end
        end
    end

    assign dmem_q_o          = q_q;
    assign dmem_ack_o        = ack_q;
    assign dmem_misaligned_o = mis_q;
    assign dmem_err_o        = err_q;
    assign dmem_page_fault_o = 1'b0;

endmodule

// File: tb/tb_riscv_dtcm.sv
// tb/tb_riscv_dtcm.sv - scoreboard bench for riscv_dtcm with zero and three wait states

module tb_riscv_dtcm;
    import riscv_dtcm_pkg::*;

`ifdef RV12_DTCM_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req  [2];
    logic        lock [2];
    logic        we   [2];
    logic [31:0] adr  [2];
    logic [31:0] d    [2];
    biu_size_t   sz   [2];
    logic [31:0] q    [2];
    logic        ack  [2];
    logic        mis  [2];
    logic        pf   [2];
    logic        err  [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] q;
        logic        mis;
        logic        err;
        int          lat;
        int          start;
        string       name;
    } exp_t;

    exp_t sb [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_dtcm #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
        .rst_ni(rst_n), .clk_i(clk), .dmem_req_i(req[0]), .dmem_lock_i(lock[0]),
        .dmem_adr_i(adr[0]), .dmem_size_i(sz[0]), .dmem_we_i(we[0]), .dmem_d_i(d[0]),
        .dmem_q_o(q[0]), .dmem_ack_o(ack[0]), .dmem_misaligned_o(mis[0]),
        .dmem_page_fault_o(pf[0]), .dmem_err_o(err[0])
    );

    riscv_dtcm #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut3 (
        .rst_ni(rst_n), .clk_i(clk), .dmem_req_i(req[1]), .dmem_lock_i(lock[1]),
        .dmem_adr_i(adr[1]), .dmem_size_i(sz[1]), .dmem_we_i(we[1]), .dmem_d_i(d[1]),
        .dmem_q_o(q[1]), .dmem_ack_o(ack[1]), .dmem_misaligned_o(mis[1]),
        .dmem_page_fault_o(pf[1]), .dmem_err_o(err[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ack[k] === 1'b1) begin
                if (sb[k].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack dut%0d: got ack=1 expected no ack", k);
                end else begin
                    exp_t e;
                    e = sb[k].pop_front();
                    chk({e.name, "_q"},   64'(q[k]),         64'(e.q));
                    chk({e.name, "_mis"}, 64'(mis[k]),       64'(e.mis));
                    chk({e.name, "_err"}, 64'(err[k]),       64'(e.err));
                    chk({e.name, "_lat"}, 64'(cyc - e.start), 64'(e.lat));
                    chk({e.name, "_pf"},  64'(pf[k]),        64'd0);
                end
            end
        end
    end

    task automatic access(input int k, input string nm, input biu_size_t s, input logic w,
                          input logic lk, input logic [31:0] a, input logic [31:0] dd,
                          input logic [31:0] eq, input logic em, input logic ee);
        exp_t e;
        bit   got;
        e.q     = eq;
        e.mis   = em;
        e.err   = ee;
        e.lat   = (em || ee) ? 1 : ((k == 1) ? 4 : 1);
        e.start = cyc;
        e.name  = nm;
        sb[k].push_back(e);
        sz[k]   = s;
        we[k]   = w;
        lock[k] = lk;
        adr[k]  = a;
        d[k]    = dd;
        req[k]  = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack[k] === 1'b1) got = 1'b1;
        end
        req[k] = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no ack expected ack within 40 cycles", nm);
            void'(sb[k].pop_back());
        end
        @(negedge clk);
        chk({nm, "_idle"}, {28'd0, ack[k], mis[k], err[k], 1'b0, q[k]}, 64'd0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 0; lock[k] = 0; we[k] = 0; adr[k] = 0; d[k] = 0; sz[k] = WORD;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk("reset_outputs", {28'd0, ack[k], mis[k], err[k], pf[k], q[k]}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        access(0, "w_deadbeef", WORD,  1, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 0);
        access(0, "r_deadbeef", WORD,  0, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 0);
        access(0, "w_11223344", WORD,  1, 0, 32'h10,   32'h11223344, 32'h0,        0, 0);
        access(0, "w_byte13",   BYTE,  1, 0, 32'h13,   32'hAA000000, 32'h0,        0, 0);
        access(0, "r_byte13",   WORD,  0, 0, 32'h10,   32'h0,        32'hAA223344, 0, 0);
        access(0, "w_hword10",  HWORD, 1, 0, 32'h10,   32'hFFFF5566, 32'h0,        0, 0);
        access(0, "r_hword10",  WORD,  0, 0, 32'h10,   32'h0,        32'hAA225566, 0, 0);
        access(0, "w_mis_word", WORD,  1, 0, 32'h12,   32'h99999999, 32'h0,        1, 0);
        access(0, "w_mis_hw",   HWORD, 1, 0, 32'h13,   32'h77777777, 32'h0,        1, 0);
        access(0, "r_after_mis",WORD,  0, 0, 32'h10,   32'h0,        32'hAA225566, 0, 0);
        access(0, "w_word0",    WORD,  1, 0, 32'h0,    32'h01020304, 32'h0,        0, 0);
        access(0, "w_err_top",  WORD,  1, 0, 32'h1000, 32'hFFFFFFFF, 32'h0,        0, 1);
        access(0, "w_err_mis",  WORD,  1, 0, 32'h1002, 32'hFFFFFFFF, 32'h0,        0, 1);
        access(0, "r_dword",    DWORD, 0, 0, 32'h8,    32'h0,        32'h0,        0, 1);
        access(0, "r_after_err",WORD,  0, 0, 32'h0,    32'h0,        32'h01020304, 0, 0);
        access(0, "w_last",     WORD,  1, 0, 32'hFFC,  32'h5A5A5A5A, 32'h0,        0, 0);
        access(0, "r_last",     WORD,  0, 0, 32'hFFC,  32'h0,        32'h5A5A5A5A, 0, 0);

        access(0, "w_clr20",    WORD,  1, 0, 32'h20,   32'h0,        32'h0,        0, 0);
        access(0, "lr_20a",     WORD,  0, 1, 32'h20,   32'h0,        32'h0,        0, 0);
        access(0, "sc_20a",     WORD,  1, 1, 32'h20,   32'h5,        32'h0,        0, 0);
        access(0, "r_sc_a",     WORD,  0, 0, 32'h20,   32'h0,        32'h5,        0, 0);
        access(0, "sc_20b",     WORD,  1, 1, 32'h20,   32'h9,        LOCK_EN ? 32'h1 : 32'h0, 0, 0);
        access(0, "r_sc_b",     WORD,  0, 0, 32'h20,   32'h0,        LOCK_EN ? 32'h5 : 32'h9, 0, 0);
        access(0, "lr_20c",     WORD,  0, 1, 32'h20,   32'h0,        LOCK_EN ? 32'h5 : 32'h9, 0, 0);
        access(0, "w_plain20",  WORD,  1, 0, 32'h20,   32'h7,        32'h0,        0, 0);
        access(0, "sc_20c",     WORD,  1, 1, 32'h20,   32'hB,        LOCK_EN ? 32'h1 : 32'h0, 0, 0);
        access(0, "r_sc_c",     WORD,  0, 0, 32'h20,   32'h0,        LOCK_EN ? 32'h7 : 32'hB, 0, 0);

        access(1, "ws_w30",     WORD,  1, 0, 32'h30,   32'h0BADF00D, 32'h0,        0, 0);
        access(1, "ws_r30",     WORD,  0, 0, 32'h30,   32'h0,        32'h0BADF00D, 0, 0);
        access(1, "ws_mis_hw",  HWORD, 0, 0, 32'h11,   32'h0,        32'h0,        1, 0);
        access(1, "ws_err",     WORD,  0, 0, 32'h2000, 32'h0,        32'h0,        0, 1);
        access(1, "ws_w40",     WORD,  1, 0, 32'h40,   32'hCAFEF00D, 32'h0,        0, 0);

        sz[1] = WORD; we[1] = 1'b1; lock[1] = 1'b0; adr[1] = 32'h40; d[1] = 32'h12345678;
        req[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++)
            chk("midreset_outputs", {28'd0, ack[k], mis[k], err[k], pf[k], q[k]}, 64'd0);
        req[1] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access(1, "ws_r40_after_rst", WORD, 0, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0, 0);

        for (int k = 0; k < 2; k++) begin
            if (sb[k].size() != 0) begin
                tests++;
                fails++;
                $display("FAIL pending_responses dut%0d: got %0d outstanding expected 0", k, sb[k].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
